// File: rtl/color_pkg.sv
// Shared definitions for the colour-sensor front end and the downstream classifier.
// Contents:
//   channel_e        - filter channel identifiers in sampling order
//   state_e          - sampler FSM states
//   FILT_*           - {S2,S3} filter-select codes of the sensor
//   SCALE_20PCT      - {S0,S1} code selecting 20 % output frequency scaling
//   filt_code()      - channel -> filter-select code
//   next_channel()   - channel -> following channel in the frame
//   timer_width()    - bit width of a down-the-middle timer able to span both windows
package color_pkg;

    typedef enum logic [1:0] {
        CH_BLUE  = 2'd0,
        CH_GREEN = 2'd1,
        CH_RED   = 2'd2,
        CH_CLEAR = 2'd3
    } channel_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_GATE    = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    localparam logic [1:0] FILT_BLUE   = 2'b01;
    localparam logic [1:0] FILT_GREEN  = 2'b11;
    localparam logic [1:0] FILT_RED    = 2'b00;
    localparam logic [1:0] FILT_CLEAR  = 2'b10;
    localparam logic [1:0] SCALE_20PCT = 2'b10;

    function automatic logic [1:0] filt_code(input channel_e ch);
        logic [1:0] code;
        case (ch)
            CH_BLUE:  code = FILT_BLUE;
            CH_GREEN: code = FILT_GREEN;
            CH_RED:   code = FILT_RED;
            CH_CLEAR: code = FILT_CLEAR;
            default:  code = FILT_BLUE;
        endcase
        return code;
    endfunction

    function automatic channel_e next_channel(input channel_e ch);
        channel_e nxt;
        case (ch)
            CH_BLUE:  nxt = CH_GREEN;
            CH_GREEN: nxt = CH_RED;
            CH_RED:   nxt = CH_CLEAR;
            CH_CLEAR: nxt = CH_BLUE;
            default:  nxt = CH_BLUE;
        endcase
        return nxt;
    endfunction

    // The timer counts 0..N-1, so clog2 of the longest window is enough.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/color_edge_sync.sv
// Synchroniser and rising-edge detector for the sensor's asynchronous square wave.
// Ports:
//   clock      in  system clock
//   reset      in  synchronous active-high reset, clears all three flops
//   async_in   in  raw sensor output
//   rise_pulse out one-cycle pulse, high in the cycle that the synchronised
//                  level is first seen high (two cycles after capture)
module color_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state values: a plain three-stage shift of the input level.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and history flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/color_freq_sampler.sv
// Colour-sensor front end: selects each filter in turn (blue, green, red, clear),
// lets the sensor settle, counts rising edges of its output over a fixed gate and
// publishes the four raw counts together as one frame.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   enable            1 = sample frames back to back, 0 = abort and idle
//   colorsignal       asynchronous sensor square wave
//   S0, S1            frequency scaling select (fixed 20 %)
//   S2, S3            filter select
//   *_cnt             per-filter counts of the last completed frame
//   sample_valid      one-cycle pulse when all four counts update
//   busy              high while a frame is in progress
module color_freq_sampler
    import color_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 6250000,
    parameter int unsigned SETTLE_CYCLES = 100000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             colorsignal,
    output logic             S0,
    output logic             S1,
    output logic             S2,
    output logic             S3,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             sample_valid,
    output logic             busy
);

    localparam int unsigned      TMR_W       = timer_width(GATE_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 32'd1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    logic rise_s;

    color_edge_sync u_sync (
        .clock      (clock),
        .reset      (reset),
        .async_in   (colorsignal),
        .rise_pulse (rise_s)
    );

    state_e             state_q, state_d;
    channel_e           chan_q, chan_d;
    logic [TMR_W-1:0]   timer_q, timer_d, timer_inc_s;
    logic [CNT_W-1:0]   work_q, work_d, work_inc_s;
    logic [CNT_W-1:0]   shadow_blue_q, shadow_blue_d;
    logic [CNT_W-1:0]   shadow_green_q, shadow_green_d;
    logic [CNT_W-1:0]   shadow_red_q, shadow_red_d;
    logic [1:0]         filt_q, filt_d;
    logic [CNT_W-1:0]   blue_cnt_q, blue_cnt_d;
    logic [CNT_W-1:0]   green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0]   red_cnt_q, red_cnt_d;
    logic [CNT_W-1:0]   clear_cnt_q, clear_cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    // FSM, timer, working count, shadows and registered outputs: next-state logic.
    always_comb begin
        state_d        = state_q;
        chan_d         = chan_q;
        timer_d        = timer_q;
        work_d         = work_q;
        shadow_blue_d  = shadow_blue_q;
        shadow_green_d = shadow_green_q;
        shadow_red_d   = shadow_red_q;
        filt_d         = filt_q;
        blue_cnt_d     = blue_cnt_q;
        green_cnt_d    = green_cnt_q;
        red_cnt_d      = red_cnt_q;
        clear_cnt_d    = clear_cnt_q;
        valid_d        = 1'b0;

        timer_inc_s = timer_q + TMR_W'(1);
        // Saturate rather than wrap so a bright scene never reads as dark.
        if (rise_s && (work_q != CNT_MAX)) begin
            work_inc_s = work_q + CNT_W'(1);
        end else begin
            work_inc_s = work_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SETTLE;
                    chan_d  = CH_BLUE;
                    filt_d  = FILT_BLUE;
                    timer_d = TMR_ZERO;
                    work_d  = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // Edges during settling are ignored: work_d stays cleared.
                if (!enable) begin
                    state_d = ST_IDLE;
                    timer_d = TMR_ZERO;
                    work_d  = CNT_ZERO;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = ST_GATE;
                    timer_d = TMR_ZERO;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    timer_d = TMR_ZERO;
                    work_d  = CNT_ZERO;
                end else if (timer_q != GATE_LAST) begin
                    timer_d = timer_inc_s;
                    work_d  = work_inc_s;
                end else begin
                    // Last gate cycle: its edge is included via work_inc_s.
                    timer_d = TMR_ZERO;
                    work_d  = CNT_ZERO;
                    case (chan_q)
                        CH_BLUE:  shadow_blue_d  = work_inc_s;
                        CH_GREEN: shadow_green_d = work_inc_s;
                        CH_RED:   shadow_red_d   = work_inc_s;
                        default:  shadow_red_d   = shadow_red_q;
                    endcase
                    if (chan_q == CH_CLEAR) begin
                        // Outputs load on entry to PUBLISH so they change in the
                        // same cycle that sample_valid is high; clear goes direct.
                        state_d     = ST_PUBLISH;
                        blue_cnt_d  = shadow_blue_q;
                        green_cnt_d = shadow_green_q;
                        red_cnt_d   = shadow_red_q;
                        clear_cnt_d = work_inc_s;
                        valid_d     = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        chan_d  = next_channel(chan_q);
                        filt_d  = filt_code(next_channel(chan_q));
                    end
                end
            end
            ST_PUBLISH: begin
                if (enable) begin
                    state_d = ST_SETTLE;
                    chan_d  = CH_BLUE;
                    filt_d  = FILT_BLUE;
                    timer_d = TMR_ZERO;
                    work_d  = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            chan_q         <= CH_BLUE;
            timer_q        <= TMR_ZERO;
            work_q         <= CNT_ZERO;
            shadow_blue_q  <= CNT_ZERO;
            shadow_green_q <= CNT_ZERO;
            shadow_red_q   <= CNT_ZERO;
            filt_q         <= FILT_BLUE;
            blue_cnt_q     <= CNT_ZERO;
            green_cnt_q    <= CNT_ZERO;
            red_cnt_q      <= CNT_ZERO;
            clear_cnt_q    <= CNT_ZERO;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            timer_q        <= timer_d;
            work_q         <= work_d;
            shadow_blue_q  <= shadow_blue_d;
            shadow_green_q <= shadow_green_d;
            shadow_red_q   <= shadow_red_d;
            filt_q         <= filt_d;
            blue_cnt_q     <= blue_cnt_d;
            green_cnt_q    <= green_cnt_d;
            red_cnt_q      <= red_cnt_d;
            clear_cnt_q    <= clear_cnt_d;
            valid_q        <= valid_d;
            busy_q         <= busy_d;
        end
    end

    assign S0           = SCALE_20PCT[1];
    assign S1           = SCALE_20PCT[0];
    assign S2           = filt_q[1];
    assign S3           = filt_q[0];
    assign blue_cnt     = blue_cnt_q;
    assign green_cnt    = green_cnt_q;
    assign red_cnt      = red_cnt_q;
    assign clear_cnt    = clear_cnt_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule
